// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: widths, reset/bubble constants and
// the IF fetch FSM state encoding.
package pipe_pkg;

   localparam int INST_W = 32;
   localparam int ADDR_W = 32;

   localparam logic [ADDR_W-1:0] RESET_PC_DEF = 32'h0040_0000;
   localparam logic [INST_W-1:0] NOP_INST_DEF = 32'h0000_0000;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } fetch_state_t;

   function automatic logic [ADDR_W-1:0] pc_plus4(
      input logic [ADDR_W-1:0] pc
   );
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry skid buffer holding a fetched word while ID stalls.
// Ports: load/take/clear controls, din in; valid flag and data out.
module if_skid_buf
   import pipe_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              take,
   input  logic              clear,
   input  logic [INST_W-1:0] din,
   output logic              valid,
   output logic [INST_W-1:0] data
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (clear || take) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= din;
      end
   end

endmodule

// File: rtl/if_fetch_unit.sv
// IF stage: PC register, imem req/ack fetch FSM, IF/ID register.
// Ports: next_pc/stall/flush control in; imem_req/addr/ack/rdata;
// pc_out, id_inst/id_npc/id_valid, fetch_busy out.
// Optional IF_FETCH_PERF_EN adds perf_fetch_cnt / perf_wait_cnt.
module if_fetch_unit
   import pipe_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF,
   parameter logic [INST_W-1:0] NOP_INST = NOP_INST_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] next_pc,
   input  logic              stall,
   input  logic              flush,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [INST_W-1:0] imem_rdata,
   output logic [ADDR_W-1:0] pc_out,
   output logic [INST_W-1:0] id_inst,
   output logic [ADDR_W-1:0] id_npc,
   output logic              id_valid,
   output logic              fetch_busy
`ifdef IF_FETCH_PERF_EN
   ,
   output logic [31:0]       perf_fetch_cnt,
   output logic [31:0]       perf_wait_cnt
`endif
);

   localparam logic [ADDR_W-1:0] ALIGN = 32'hFFFF_FFFC;

   fetch_state_t      state;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] redirect;
   logic              drop;
   logic [ADDR_W-1:0] npc_al;
   logic              in_wait;
   logic              in_hold;
   logic              skid_load;
   logic              skid_take;
   logic              skid_valid;
   logic [INST_W-1:0] skid_data;

   assign npc_al     = next_pc & ALIGN;
   assign in_wait    = (state == S_WAIT);
   assign in_hold    = (state == S_HOLD);
   assign imem_req   = in_wait;
   assign imem_addr  = pc;
   assign pc_out     = pc;
   assign fetch_busy = in_wait & ~imem_ack;

   // Skid only captures a live (not dropped) word when ID stalls.
   assign skid_load = in_wait & imem_ack & stall
                    & ~flush & ~drop;
   assign skid_take = in_hold & ~stall & ~flush;

   if_skid_buf u_skid (
      .clk   (clk),
      .rst   (rst),
      .load  (skid_load),
      .take  (skid_take),
      .clear (flush),
      .din   (imem_rdata),
      .valid (skid_valid),
      .data  (skid_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         pc       <= RESET_PC & ALIGN;
         redirect <= '0;
         drop     <= 1'b0;
         id_inst  <= NOP_INST;
         id_npc   <= '0;
         id_valid <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               state <= S_WAIT;
               if (flush) begin
                  pc       <= npc_al;
                  id_inst  <= NOP_INST;
                  id_valid <= 1'b0;
               end
            end
            S_WAIT: begin
               if (flush) begin
                  id_inst  <= NOP_INST;
                  id_valid <= 1'b0;
                  if (imem_ack) begin
                     pc   <= npc_al;
                     drop <= 1'b0;
                  end else begin
                     // Address must stay put until the
                     // outstanding access completes.
                     drop     <= 1'b1;
                     redirect <= npc_al;
                  end
               end else if (drop) begin
                  if (imem_ack) begin
                     drop <= 1'b0;
                     pc   <= redirect;
                  end
                  if (!stall) begin
                     id_inst  <= NOP_INST;
                     id_valid <= 1'b0;
                  end
               end else if (imem_ack) begin
                  if (stall) begin
                     state <= S_HOLD;
                  end else begin
                     id_inst  <= imem_rdata;
                     id_npc   <= pc_plus4(pc);
                     id_valid <= 1'b1;
                     pc       <= npc_al;
                  end
               end else if (!stall) begin
                  id_inst  <= NOP_INST;
                  id_valid <= 1'b0;
               end
            end
            S_HOLD: begin
               if (flush) begin
                  id_inst  <= NOP_INST;
                  id_valid <= 1'b0;
                  pc       <= npc_al;
                  state    <= S_WAIT;
               end else if (!stall) begin
                  id_inst  <= skid_data;
                  id_npc   <= pc_plus4(pc);
                  id_valid <= skid_valid;
                  pc       <= npc_al;
                  state    <= S_WAIT;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef IF_FETCH_PERF_EN
   logic fetch_load;

   assign fetch_load = (in_wait & imem_ack & ~stall
                        & ~flush & ~drop) | skid_take;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_fetch_cnt <= '0;
         perf_wait_cnt  <= '0;
      end else begin
         if (fetch_load && perf_fetch_cnt != 32'hFFFF_FFFF)
            perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
         if (fetch_busy && perf_wait_cnt != 32'hFFFF_FFFF)
            perf_wait_cnt <= perf_wait_cnt + 32'd1;
      end
   end
`endif

endmodule
